// File: rtl/div_pkg.sv
// div_pkg: shared op encodings, one-hot FSM states and special-case constants
// for the divider issue controller.
package div_pkg;
   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_MOD  = 2'b01;
   localparam logic [1:0] OP_DIVU = 2'b10;
   localparam logic [1:0] OP_MODU = 2'b11;
   localparam logic [3:0] ST_IDLE  = 4'b0001;
   localparam logic [3:0] ST_ISSUE = 4'b0010;
   localparam logic [3:0] ST_WAIT  = 4'b0100;
   localparam logic [3:0] ST_DONE  = 4'b1000;
   typedef enum logic [3:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      WAIT  = ST_WAIT,
      DONE  = ST_DONE
   } state_t;
   localparam logic [31:0] QUO_ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN      = 32'h8000_0000;
endpackage

// File: rtl/div_special_detect.sv
// div_special_detect: flags divide-by-zero and signed overflow and forms the
// architectural result for them so the core can be skipped.
// Ports: op/src1/src2 request fields in; hit = special case, result = value
// to write back when hit.
module div_special_detect
   import div_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   output logic        hit,
   output logic [31:0] result
);
   logic zero, ovf, rem;
   always_comb begin
      zero   = src2 == '0;
      ovf    = (op == OP_DIV || op == OP_MOD) && src1 == INT_MIN && src2 == QUO_ALL_ONES;
      rem    = op == OP_MOD || op == OP_MODU;
      hit    = zero | ovf;
      result = zero ? (rem ? src1 : QUO_ALL_ONES) : (rem ? '0 : INT_MIN);
   end
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues one divide/modulo request to the SRT divider core,
// waits for completion, selects quotient or remainder and holds it for writeback.
// Ports: req_* request handshake from execute, flush kills the in-flight op,
// div_* core launch/operands/results, res_* writeback handshake, busy = not idle.
// Build option: DIV_SPECIAL_BYPASS_EN resolves zero-divisor and signed overflow
// locally (straight to DONE) instead of sending them to the core.
module div_issue_ctrl
   import div_pkg::*;
#(
   parameter int TAG_W = 5
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_src1,
   input  logic [31:0]      req_src2,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             div_enable,
   output logic             div_sign_en,
   output logic [31:0]      div_op1,
   output logic [31:0]      div_op2,
   input  logic             div_ready,
   input  logic             div_complete,
   input  logic [31:0]      div_quo,
   input  logic [31:0]      div_rem,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             busy
);
   state_t state, state_nx;
   logic [1:0] op;
   logic kill, accept, byp_hit;
   logic [31:0] byp_res;
`ifdef DIV_SPECIAL_BYPASS_EN
   div_special_detect u_detect (
      .op     (req_op),
      .src1   (req_src1),
      .src2   (req_src2),
      .hit    (byp_hit),
      .result (byp_res)
   );
`else
   assign byp_hit = 1'b0;
   assign byp_res = '0;
`endif
   assign accept = req_valid & req_ready;
   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      div_enable = 1'b0;
      res_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy      = 1'b0;
            req_ready = ~flush;
            if (req_valid & ~flush) state_nx = byp_hit ? DONE : ISSUE;
         end
         ISSUE: begin
            div_enable = div_ready & ~flush;
            state_nx   = flush ? IDLE : div_ready ? WAIT : ISSUE;
         end
         // the core cannot be aborted: a flush here only marks the result dead
         WAIT: if (div_complete) state_nx = (kill | flush) ? IDLE : DONE;
         DONE: begin
            res_valid = 1'b1;
            if (flush | res_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         op          <= OP_DIV;
         div_sign_en <= 1'b0;
         div_op1     <= '0;
         div_op2     <= '0;
         res_tag     <= '0;
         res_data    <= '0;
         kill        <= 1'b0;
      end else begin
         if (accept) begin
            op          <= req_op;
            div_sign_en <= req_op != OP_DIVU && req_op != OP_MODU;
            div_op1     <= req_src1;
            div_op2     <= req_src2;
            res_tag     <= req_tag;
            if (byp_hit) res_data <= byp_res;
         end
         if (state == WAIT && div_complete && !(kill | flush))
            res_data <= (op == OP_MOD || op == OP_MODU) ? div_rem : div_quo;
         kill <= state == WAIT && !div_complete && (kill | flush);
      end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed plus randomized checks of div_issue_ctrl against a
// behavioural divider core and an arithmetic result model.
module tb_div_issue_ctrl;
   localparam int TAG_W = 5;
   localparam logic [1:0] DIV = 2'b00, MOD = 2'b01, DIVU = 2'b10, MODU = 2'b11;
   logic clk = 0, rstn = 0;
   logic req_valid = 0, req_ready;
   logic [1:0] req_op = 0;
   logic [31:0] req_src1 = 0, req_src2 = 0;
   logic [TAG_W-1:0] req_tag = 0;
   logic flush = 0, div_enable, div_sign_en;
   logic [31:0] div_op1, div_op2;
   logic div_ready, div_complete;
   logic [31:0] div_quo, div_rem;
   logic res_valid, res_ready = 0, busy;
   logic [31:0] res_data;
   logic [TAG_W-1:0] res_tag;
   int ncmp = 0, nfail = 0;
   logic core_busy = 0, core_done = 0, spur = 0, stall = 0;
   int lat = 2, cnt = 0;
   logic [31:0] cq = 0, cr = 0;

   always #5 clk = ~clk;

   div_issue_ctrl #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
      .flush(flush), .div_enable(div_enable), .div_sign_en(div_sign_en),
      .div_op1(div_op1), .div_op2(div_op2), .div_ready(div_ready),
      .div_complete(div_complete), .div_quo(div_quo), .div_rem(div_rem),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_tag(res_tag), .busy(busy)
   );

   function automatic logic [63:0] core_div(logic s, logic [31:0] a, logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 0) return {32'hFFFF_FFFF, a};
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      if (s) return {sa / sb, sa % sb};
      return {a / b, a % b};
   endfunction

   // architectural result computed in 64-bit arithmetic, no special-case table
   function automatic logic [31:0] ref_res(logic [1:0] op, logic [31:0] a, logic [31:0] b);
      longint x, y, q, r;
      if (b == 0) return op[0] ? a : 32'hFFFF_FFFF;
      if (op[1]) begin
         x = longint'({32'b0, a});
         y = longint'({32'b0, b});
      end else begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end
      q = x / y;
      r = x % y;
      return op[0] ? r[31:0] : q[31:0];
   endfunction

   function automatic bit exp_bypass(logic [1:0] op, logic [31:0] a, logic [31:0] b);
`ifdef DIV_SPECIAL_BYPASS_EN
      return b == 0 || (!op[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`else
      return 1'b0;
`endif
   endfunction

   assign div_ready    = ~core_busy & ~stall;
   assign div_complete = core_done | spur;
   assign div_quo      = spur ? 32'hDEAD_0000 : cq;
   assign div_rem      = spur ? 32'h0000_BEEF : cr;

   always @(posedge clk or negedge rstn)
      if (!rstn) begin
         core_busy <= 0;
         core_done <= 0;
         cnt       <= 0;
      end else begin
         core_done <= 0;
         if (core_busy) begin
            if (cnt == 0) begin
               core_busy <= 0;
               core_done <= 1;
            end else cnt <= cnt - 1;
         end else if (div_enable) begin
            core_busy <= 1;
            cnt       <= lat;
            {cq, cr}  <= core_div(div_sign_en, div_op1, div_op2);
         end
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_req_ready"}, req_ready, 1);
      chk({p, "_div_enable"}, div_enable, 0);
      chk({p, "_div_sign_en"}, div_sign_en, 0);
      chk({p, "_div_op1"}, div_op1, 0);
      chk({p, "_div_op2"}, div_op2, 0);
      chk({p, "_res_valid"}, res_valid, 0);
      chk({p, "_res_data"}, res_data, 0);
      chk({p, "_res_tag"}, res_tag, 0);
      chk({p, "_busy"}, busy, 0);
   endtask

   // presents one request for one cycle; returns at the negedge of cycle T+1
   task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tg);
      @(negedge clk);
      req_valid = 1; req_op = op; req_src1 = a; req_src2 = b; req_tag = tg;
      #1;
      chk("req_ready_idle", req_ready, 1);
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tg, input int st, input int hold);
      logic [31:0] exp;
      bit byp;
      int en_cnt, en_at, cmp_at, rv_at, i;
      exp = ref_res(op, a, b);
      byp = exp_bypass(op, a, b);
      en_cnt = 0; en_at = -1; cmp_at = -1; rv_at = -1; i = 0;
      stall = st > 0;
      accept(op, a, b, tg);
      while (rv_at < 0 && i < 200) begin
         if (i >= st) stall = 0;
         #1;
         if (div_enable) begin
            en_cnt++;
            if (en_at < 0) begin
               en_at = i;
               chk("launch_sign_en", div_sign_en, !op[1]);
               chk("launch_op1", div_op1, a);
               chk("launch_op2", div_op2, b);
            end
         end
         if (div_complete && cmp_at < 0) cmp_at = i;
         if (res_valid) rv_at = i;
         else begin
            chk("req_ready_busy", req_ready, 0);
            @(negedge clk);
            i++;
         end
      end
      stall = 0;
      chk("res_timeout", rv_at >= 0, 1);
      if (byp) begin
         chk("bypass_latency", rv_at, 0);
         chk("bypass_no_enable", en_cnt, 0);
      end else begin
         chk("enable_count", en_cnt, 1);
         chk("launch_cycle", en_at, st);
         chk("res_after_complete", rv_at, cmp_at + 1);
      end
      chk("res_data", res_data, exp);
      chk("res_tag", res_tag, tg);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         #1;
         chk("hold_res_valid", res_valid, 1);
         chk("hold_res_data", res_data, exp);
         chk("hold_res_tag", res_tag, tg);
         chk("hold_req_ready", req_ready, 0);
      end
      res_ready = 1;
      @(negedge clk);
      res_ready = 0;
      #1;
      chk("retire_res_valid", res_valid, 0);
      chk("retire_busy", busy, 0);
      chk("retire_req_ready", req_ready, 1);
   endtask

   initial begin
      logic [31:0] a, b, saved;
      logic [1:0] op;
      int seen;
      repeat (2) @(negedge clk);
      #1;
      chk_reset("reset");
      rstn = 1;
      lat = 3;
      run_op(DIV, 100, 7, 5'h11, 0, 0);
      run_op(MOD, 100, 7, 5'h12, 0, 0);
      run_op(MOD, 32'hFFFF_FFF9, 2, 5'h13, 1, 0);
      run_op(DIV, 32'hFFFF_FFF9, 2, 5'h14, 0, 1);
      run_op(DIVU, 32'hFFFF_FFFF, 2, 5'h15, 0, 0);
      run_op(MODU, 32'hFFFF_FFFF, 2, 5'h16, 2, 0);
      run_op(DIV, 5, 0, 5'h17, 0, 0);
      run_op(MOD, 5, 0, 5'h18, 0, 0);
      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'h19, 0, 0);
      run_op(DIVU, 1234567, 89, 5'h1A, 0, 3);

      // flush two cycles into WAIT: the result must never appear
      lat = 8;
      accept(DIV, 1000, 3, 5'h03);
      #1;
      chk("fw_launch", div_enable, 1);
      repeat (2) @(negedge clk);
      flush = 1;
      #1;
      chk("fw_req_ready", req_ready, 0);
      @(negedge clk);
      flush = 0;
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         #1;
         chk("fw_res_valid", res_valid, 0);
         chk("fw_req_ready_wait", req_ready, 0);
         if (div_complete) seen = 1;
         else @(negedge clk);
      end
      chk("fw_complete_seen", seen, 1);
      @(negedge clk);
      #1;
      chk("fw_after_res_valid", res_valid, 0);
      chk("fw_after_busy", busy, 0);
      chk("fw_after_req_ready", req_ready, 1);
      lat = 2;
      run_op(DIV, 20, 4, 5'h04, 0, 0);

      // flush in ISSUE while the core is not ready: no launch
      stall = 1;
      accept(DIVU, 77, 7, 5'h05);
      #1;
      chk("fi_busy", busy, 1);
      chk("fi_no_enable", div_enable, 0);
      flush = 1;
      @(negedge clk);
      flush = 0;
      stall = 0;
      #1;
      chk("fi_busy_after", busy, 0);
      chk("fi_no_enable_after", div_enable, 0);
      chk("fi_core_idle", core_busy, 0);

      // flush together with a request in IDLE: not accepted
      @(negedge clk);
      req_valid = 1; req_op = DIV; req_src1 = 9; req_src2 = 3;
      flush = 1;
      #1;
      chk("fr_req_ready", req_ready, 0);
      @(negedge clk);
      req_valid = 0;
      flush = 0;
      #1;
      chk("fr_busy", busy, 0);

      // spurious completion in IDLE is ignored
      saved = res_data;
      @(negedge clk);
      spur = 1;
      @(negedge clk);
      spur = 0;
      #1;
      chk("spur_idle_busy", busy, 0);
      chk("spur_idle_res_valid", res_valid, 0);
      chk("spur_idle_res_data", res_data, saved);

      // in DONE: spurious completion leaves the result alone, flush drops it
      accept(DIV, 81, 9, 5'h09);
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         #1;
         if (res_valid) seen = 1;
         else @(negedge clk);
      end
      chk("fd_res_valid", seen, 1);
      @(negedge clk);
      spur = 1;
      @(negedge clk);
      spur = 0;
      #1;
      chk("fd_spur_res_valid", res_valid, 1);
      chk("fd_spur_res_data", res_data, 9);
      flush = 1;
      @(negedge clk);
      flush = 0;
      #1;
      chk("fd_res_valid_dropped", res_valid, 0);
      chk("fd_busy", busy, 0);

      // reset in the middle of WAIT
      lat = 6;
      accept(DIV, 50, 5, 5'h1F);
      repeat (2) @(negedge clk);
      rstn = 0;
      #1;
      chk_reset("midreset");
      @(negedge clk);
      rstn = 1;
      lat = 1;
      run_op(MOD, 50, 7, 5'h02, 0, 0);

      for (int n = 0; n < 40; n++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: a = $urandom_range(0, 1000);
            1: a = 32'h8000_0000;
            2: a = -32'($urandom_range(1, 1000));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0: b = 0;
            1: b = 32'hFFFF_FFFF;
            2: b = $urandom_range(1, 50);
            3: b = -32'($urandom_range(1, 50));
            default: b = $urandom;
         endcase
         lat = $urandom_range(0, 6);
         run_op(op, a, b, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
